button_event_conditioner: RTL and testbench

Converts the five raw board pushbuttons into clean, synchronous, one-hot press events for the Simon game controller. Each button press produces exactly one event, held under a valid/ready handshake, so the controller never needs to clock logic off button edges. Contains a 2-flop synchronizer, a shared debounce FSM on the 5-bit vector, multi-press rejection and a 1-deep event buffer.

---
 rtl/button_event_conditioner.sv | 205 ++++++++++++++++++++
 tb/tb_button_event_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_conditioner.sv
// -----------------------------------------------------------------------------
// button_event_conditioner
//
// Turns the five raw board pushbuttons into clean, synchronous, one-hot press
// events for the Simon game controller. Each accepted single-button press
// produces exactly one event, which is held in a 1-deep buffer under a
// valid/ready handshake.
//
// Pipeline: 2-flop synchronizer -> shared debounce FSM on the 5-bit vector ->
//           multi-press rejection -> 1-deep event buffer.
//
// Handshake: press_valid/press_code are registered and stay stable until a
// clk edge sees press_valid && press_ready; that edge empties the buffer
// unless a new event arrives on the same edge, in which case the new event
// replaces the old one. A new event that arrives while the buffer is full and
// press_ready is low is dropped and reported on overflow. press_ready while
// press_valid is low is ignored.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high; clears every flop
//   buttons[4:0] raw pad levels {start, down, right, left, up}, active-high
//   press_valid  buffer holds an unconsumed press
//   press_code   one-hot code of the buffered press (0 when press_valid=0)
//   press_ready  consumer accepts the buffered press on this edge
//   held[4:0]    debounced accepted pattern while pressed/releasing, else 0
//   multi_error  one-cycle pulse: accepted pattern had more than one bit set
//   overflow     one-cycle pulse: new press dropped because buffer was full
//   o_dbg_state  current debounce FSM state (debug visibility only)
// -----------------------------------------------------------------------------
module button_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] buttons,
  output logic       press_valid,
  output logic [4:0] press_code,
  input  logic       press_ready,
  output logic [4:0] held,
  output logic       multi_error,
  output logic       overflow,
  output logic [1:0] o_dbg_state
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_cand;
  logic [4:0]    w_cand_nxt;
  logic [4:0]    r_held;
  logic [4:0]    w_held_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_cnt_done;
  logic          w_accept;
  logic          w_single;
  logic          w_event;
  logic          r_valid;
  logic [4:0]    r_code;
  logic          r_multi;
  logic          r_ovf;

  // The counter value already includes the current sample, so the stable run
  // is complete when this sample brings it to DEBOUNCE_CYCLES.
  assign w_cnt_inc  = r_cnt + ONE;
  assign w_cnt_done = (w_cnt_inc == LAST);

  // Candidate is always nonzero when it is accepted; clearing its lowest set
  // bit leaves zero exactly when a single button is down.
  assign w_single = ((r_cand & (r_cand - 5'd1)) == 5'd0);
  assign w_event  = w_accept && w_single;

  // ---------------------------------------------------------------------------
  // Synchronizer and FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= 5'd0;
      r_held  <= 5'd0;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_held_nxt  = r_held;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_sync2 != 5'd0) begin
          w_state_nxt = ST_ARMING;
          w_cand_nxt  = r_sync2;
          w_cnt_nxt   = ONE;
        end
      end
      ST_ARMING: begin
        if (r_sync2 == 5'd0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_sync2 != r_cand) begin
          // Pattern changed mid-bounce: restart the run on the new pattern.
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = ONE;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_HELD;
          w_held_nxt  = r_cand;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HELD: begin
        // Additional buttons pressed while held are ignored.
        if (r_sync2 == 5'd0) begin
          w_state_nxt = ST_RELEASING;
          w_cnt_nxt   = ONE;
        end
      end
      ST_RELEASING: begin
        if (r_sync2 != 5'd0) begin
          // Release bounce: still the same press, no new event.
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_IDLE;
          w_held_nxt  = 5'd0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_held_nxt  = 5'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event buffer and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_code  <= 5'd0;
      r_multi <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_multi <= w_accept && !w_single;
      r_ovf   <= 1'b0;
      if (w_event) begin
        // A consume on the same edge frees the slot for the new event.
        if (!r_valid || press_ready) begin
          r_valid <= 1'b1;
          r_code  <= r_cand;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && press_ready) begin
        r_valid <= 1'b0;
        r_code  <= 5'd0;
      end
    end
  end

  assign press_valid = r_valid;
  assign press_code  = r_code;
  assign held        = r_held;
  assign multi_error = r_multi;
  assign overflow    = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_button_event_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_event_conditioner
//
// Bench for button_event_conditioner with DEBOUNCE_CYCLES=4. A reference model
// describes the behaviour as windows over the synchronized sample history:
// a press is accepted when the last N samples are one identical nonzero
// pattern, a release when the last N samples are all zero.
// -----------------------------------------------------------------------------
module tb_button_event_conditioner;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic [4:0] buttons;
  logic       press_ready;
  logic       press_valid;
  logic [4:0] press_code;
  logic [4:0] held;
  logic       multi_error;
  logic       overflow;
  logic [1:0] dbg_state;

  int n_checks;
  int n_err;

  button_event_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons     (buttons),
    .press_valid (press_valid),
    .press_code  (press_code),
    .press_ready (press_ready),
    .held        (held),
    .multi_error (multi_error),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [4:0] raw_q[$];
  logic [4:0] sync_q[$];
  bit         m_pressed;
  logic [4:0] m_held;
  logic       m_valid;
  logic [4:0] m_code;
  logic       m_multi;
  logic       m_ovf;

  task automatic model_reset();
    raw_q.delete();
    sync_q.delete();
    m_pressed = 0;
    m_held    = 5'd0;
    m_valid   = 1'b0;
    m_code    = 5'd0;
    m_multi   = 1'b0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] b, input logic r);
    logic [4:0] s;
    bit         all_eq;
    bit         evt;
    // The FSM sees the raw level sampled two edges earlier.
    raw_q.push_back(b);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    s = (raw_q.size() == 3) ? raw_q[0] : 5'd0;
    sync_q.push_back(s);
    if (sync_q.size() > N) void'(sync_q.pop_front());
    all_eq = (sync_q.size() == N);
    foreach (sync_q[i]) if (sync_q[i] != s) all_eq = 0;
    m_multi = 1'b0;
    m_ovf   = 1'b0;
    evt     = 0;
    if (!m_pressed) begin
      if (all_eq && s != 5'd0) begin
        m_pressed = 1;
        m_held    = s;
        if ($countones(s) == 1) evt = 1;
        else m_multi = 1'b1;
      end
    end else if (all_eq && s == 5'd0) begin
      m_pressed = 0;
      m_held    = 5'd0;
    end
    if (evt) begin
      if (!m_valid || r) begin
        m_valid = 1'b1;
        m_code  = s;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
      m_code  = 5'd0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking and driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs (called at posedge+1), take one edge, compare against model.
  task automatic cycle(input logic [4:0] b, input logic r);
    buttons     = b;
    press_ready = r;
    @(posedge clk);
    #1;
    model_edge(b, r);
    chk("press_valid", {4'd0, press_valid}, {4'd0, m_valid});
    chk("press_code",  press_code, m_code);
    chk("held",        held, m_held);
    chk("multi_error", {4'd0, multi_error}, {4'd0, m_multi});
    chk("overflow",    {4'd0, overflow}, {4'd0, m_ovf});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {4'd0, press_valid}, 5'd0);
    chk({tag, "_code"},  press_code, 5'd0);
    chk({tag, "_held"},  held, 5'd0);
    chk({tag, "_multi"}, {4'd0, multi_error}, 5'd0);
    chk({tag, "_ovf"},   {4'd0, overflow}, 5'd0);
  endtask

  // Asserted away from the clock edge; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_all_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle_out(input int n);
    for (int i = 0; i < n; i++) cycle(5'd0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: press up with ready high, then release
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] btn;
    logic       rdy;
    logic       exp_valid;
    logic [4:0] exp_code;
    logic [4:0] exp_held;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int         cnt_a;
    int         cnt_b;
    int         first;
    bit         dropped;
    logic [4:0] b;

    n_checks    = 0;
    n_err       = 0;
    reset       = 1'b0;
    buttons     = 5'd0;
    press_ready = 1'b0;
    model_reset();

    // Edge k=0 is the first edge sampling the press; accept after k=N+1,
    // consume on the next edge; release sampled from k=8, cleared after k=13.
    for (int k = 0; k < 16; k++) begin
      tbl[k].btn       = (k < 8) ? 5'b00001 : 5'b00000;
      tbl[k].rdy       = 1'b1;
      tbl[k].exp_valid = (k == N + 1);
      tbl[k].exp_code  = (k == N + 1) ? 5'b00001 : 5'b00000;
      tbl[k].exp_held  = (k >= N + 1 && k <= 8 + N) ? 5'b00001 : 5'b00000;
    end

    #2;
    do_reset("reset0");

    for (int k = 0; k < 16; k++) begin
      cycle(tbl[k].btn, tbl[k].rdy);
      chk($sformatf("tbl%0d_valid", k), {4'd0, press_valid}, {4'd0, tbl[k].exp_valid});
      chk($sformatf("tbl%0d_code", k), press_code, tbl[k].exp_code);
      chk($sformatf("tbl%0d_held", k), held, tbl[k].exp_held);
    end

    // Bounce on left: toggles every 2 cycles for 12 cycles, then steady.
    cnt_a = 0;
    first = -1;
    for (int k = 0; k < 24; k++) begin
      b = (k >= 12 || ((k / 2) % 2 == 0)) ? 5'b00010 : 5'b00000;
      cycle(b, 1'b1);
      if (press_valid) begin
        cnt_a++;
        if (first < 0) first = k;
        chk("bounce_code", press_code, 5'b00010);
      end
    end
    chk_int("bounce_events", cnt_a, 1);
    chk_int("bounce_edge", first, 12 + N + 1);
    idle_out(8);

    // Two buttons together: rejected, held reflects the pattern.
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(5'b01100, 1'b1);
      if (multi_error) cnt_a++;
      if (press_valid) cnt_b++;
    end
    chk_int("multi_pulses", cnt_a, 1);
    chk_int("multi_valids", cnt_b, 0);
    chk("multi_held", held, 5'b01100);
    idle_out(8);

    // Buffer full: start, release, up, all with ready low.
    cnt_a = 0;
    for (int k = 0; k < 10; k++) cycle(5'b10000, 1'b0);
    for (int k = 0; k < 8; k++) cycle(5'b00000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(5'b00001, 1'b0);
      if (overflow) cnt_a++;
    end
    chk_int("ovf_pulses", cnt_a, 1);
    chk("ovf_code_kept", press_code, 5'b10000);
    chk("ovf_valid_kept", {4'd0, press_valid}, 5'd1);
    cycle(5'b00001, 1'b1);
    chk("ovf_consumed", {4'd0, press_valid}, 5'd0);
    idle_out(8);

    // Release glitch of 3 zero cycles while right is held.
    cnt_a   = 0;
    dropped = 0;
    for (int k = 0; k < 23; k++) begin
      b = (k >= 10 && k < 13) ? 5'b00000 : 5'b00100;
      cycle(b, 1'b1);
      if (press_valid) cnt_a++;
      if (k >= N + 1 && held != 5'b00100) dropped = 1;
    end
    chk_int("glitch_events", cnt_a, 1);
    chk_int("glitch_held_dropped", int'(dropped), 0);
    idle_out(8);

    // Reset during arming, then during held with an event pending.
    for (int k = 0; k < 3; k++) cycle(5'b00001, 1'b0);
    do_reset("rst_arming");
    for (int k = 0; k < 8; k++) cycle(5'b00001, 1'b0);
    chk("pre_rst_valid", {4'd0, press_valid}, 5'd1);
    do_reset("rst_held");
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      cycle(5'b00001, 1'b0);
      if (press_valid && first < 0) first = k;
    end
    chk_int("rst_fresh_edge", first, N + 2);
    idle_out(8);

    // Randomized segments against the model.
    b = 5'd0;
    for (int seg = 0; seg < 160; seg++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       b = 5'd0;
        1, 2:    b = 5'b00001 << $urandom_range(0, 4);
        3:       b = 5'($urandom_range(0, 31));
        default: b = b;
      endcase
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) cycle(b, 1'($urandom_range(0, 1)));
    end
    idle_out(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
